// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencing controller: state codes, redirect sources and
// default reset/interrupt addresses.
package fetch_pkg;

  localparam logic [1:0] REQ  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_JI,
    RD_JR,
    RD_IRQ
  } redir_src_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'hC000_0000;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Combinational priority select of redirect sources (irq > jr > ji).
// Interrupt participation is enabled by defining FETCH_IRQ_EN.
module fetch_redirect_arb #(
  parameter logic [31:0] IRQ_VEC = fetch_pkg::IRQ_VEC
) (
  input  logic        irq,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  input  logic        ji_valid,
  input  logic [31:0] ji_target,
  output logic        redir_v,
  output logic [31:0] redir_pc
);
  import fetch_pkg::*;

  redir_src_e src;

  // Later assignments override earlier ones, giving the priority order.
  always_comb begin
    src = RD_NONE;
    if (ji_valid) src = RD_JI;
    if (jr_valid) src = RD_JR;
`ifdef FETCH_IRQ_EN
    if (irq) src = RD_IRQ;
`endif
  end

  always_comb begin
    redir_pc = '0;
    case (src)
      RD_JI:   redir_pc = ji_target;
      RD_JR:   redir_pc = jr_target;
`ifdef FETCH_IRQ_EN
      RD_IRQ:  redir_pc = IRQ_VEC;
`endif
      default: redir_pc = '0;
    endcase
  end

  assign redir_v = (src != RD_NONE);

`ifndef FETCH_IRQ_EN
  logic unused_irq_in;
  assign unused_irq_in = irq ^ (^IRQ_VEC);
`endif

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one icache request at a time, squashes stale
// responses after redirects and holds the fetched instruction while decode stalls.
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter logic [31:0] IRQ_VEC  = fetch_pkg::IRQ_VEC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  input  logic        ji_valid,
  input  logic [31:0] ji_target,
  input  logic        irq,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_rsp_valid,
  input  logic [31:0] ic_rsp_isn,
  output logic        fe_valid,
  output logic [31:0] fe_pc,
  output logic [31:0] fe_isn,
  output logic [31:0] n_pc
);
  import fetch_pkg::*;

  localparam logic [31:0] Step = 32'(PC_STEP);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        kill_q, kill_d;
  logic        fe_valid_q, fe_valid_d;
  logic [31:0] fe_pc_q, fe_pc_d;
  logic [31:0] fe_isn_q, fe_isn_d;

  logic        redir_v;
  logic [31:0] redir_pc;

  fetch_redirect_arb #(
    .IRQ_VEC (IRQ_VEC)
  ) u_arb (
    .irq       (irq),
    .jr_valid  (jr_valid),
    .jr_target (jr_target),
    .ji_valid  (ji_valid),
    .ji_target (ji_target),
    .redir_v   (redir_v),
    .redir_pc  (redir_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    kill_d     = kill_q;
    fe_valid_d = fe_valid_q;
    fe_pc_d    = fe_pc_q;
    fe_isn_d   = fe_isn_q;
    case (state_q)
      REQ: begin
        if (redir_v) begin
          pc_d = redir_pc;
          // The old address is accepted this cycle, so its response must be squashed.
          if (ic_req_ready) begin
            state_d   = WAIT;
            kill_d    = 1'b1;
            pend_v_d  = 1'b1;
            pend_pc_d = redir_pc;
          end
        end else if (ic_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ic_rsp_valid) begin
          if (kill_q || redir_v) begin
            if (redir_v) begin
              pc_d = redir_pc;
            end else if (pend_v_q) begin
              pc_d = pend_pc_q;
            end
            pend_v_d = 1'b0;
            kill_d   = 1'b0;
            state_d  = REQ;
          end else begin
            fe_valid_d = 1'b1;
            fe_pc_d    = pc_q;
            fe_isn_d   = ic_rsp_isn;
            pc_d       = pc_q + Step;
            state_d    = HOLD;
          end
        end else if (redir_v) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redir_pc;
          kill_d    = 1'b1;
        end
      end
      HOLD: begin
        if (redir_v) begin
          pc_d       = redir_pc;
          fe_valid_d = 1'b0;
          state_d    = REQ;
        end else if (!stall) begin
          fe_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= '0;
      kill_q     <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_pc_q    <= '0;
      fe_isn_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      kill_q     <= kill_d;
      fe_valid_q <= fe_valid_d;
      fe_pc_q    <= fe_pc_d;
      fe_isn_q   <= fe_isn_d;
    end
  end

  // Gated by reset so no request is advertised while reset is held.
  assign ic_req_valid = rst && (state_q == REQ);
  assign ic_req_addr  = pc_q;
  assign fe_valid     = fe_valid_q;
  assign fe_pc        = fe_pc_q;
  assign fe_isn       = fe_isn_q;
  assign n_pc         = fe_pc_q + Step;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed self-checking bench for fetch_seq_ctrl with a small variable-latency icache model.
module tb_fetch_seq_ctrl;

  localparam logic [31:0] IsnKey = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        ji_valid;
  logic [31:0] ji_target;
  logic        irq;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_rsp_valid;
  logic [31:0] ic_rsp_isn;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_isn;
  logic [31:0] n_pc;

  int n_checks = 0;
  int n_errors = 0;

  int          rsp_lat = 1;
  int          cnt;
  logic [31:0] isn_q;
  logic [31:0] exp_pri;
  logic [31:0] exp_irq;

  always #5 clk = ~clk;

  fetch_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jr_valid     (jr_valid),
    .jr_target    (jr_target),
    .ji_valid     (ji_valid),
    .ji_target    (ji_target),
    .irq          (irq),
    .ic_req_valid (ic_req_valid),
    .ic_req_addr  (ic_req_addr),
    .ic_req_ready (ic_req_ready),
    .ic_rsp_valid (ic_rsp_valid),
    .ic_rsp_isn   (ic_rsp_isn),
    .fe_valid     (fe_valid),
    .fe_pc        (fe_pc),
    .fe_isn       (fe_isn),
    .n_pc         (n_pc)
  );

  // Icache: one response rsp_lat cycles after accept; instruction word derived from the address.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 0;
      isn_q <= '0;
    end else if (ic_req_valid && ic_req_ready) begin
      cnt   <= rsp_lat;
      isn_q <= ic_req_addr ^ IsnKey;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  assign ic_rsp_valid = (cnt == 1);
  assign ic_rsp_isn   = isn_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT in REQ; ends at the negedge in HOLD.
  task automatic fetch_one(input logic [31:0] exp_pc);
    #1;
    chk("req_valid", {31'd0, ic_req_valid}, 32'd1);
    chk("req_addr", ic_req_addr, exp_pc);
    @(negedge clk);
    chk("wait_fe_valid", {31'd0, fe_valid}, 32'd0);
    chk("wait_req_valid", {31'd0, ic_req_valid}, 32'd0);
    @(negedge clk);
    chk("hold_fe_valid", {31'd0, fe_valid}, 32'd1);
    chk("hold_fe_pc", fe_pc, exp_pc);
    chk("hold_fe_isn", fe_isn, exp_pc ^ IsnKey);
    chk("hold_n_pc", n_pc, exp_pc + 32'd4);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; irq = 1'b0;
    jr_valid = 1'b0; jr_target = '0; ji_valid = 1'b0; ji_target = '0;
    ic_req_ready = 1'b1;
`ifdef FETCH_IRQ_EN
    exp_pri = 32'hC000_0000;
    exp_irq = 32'hC000_0000;
`else
    exp_pri = 32'h0000_0200;
    exp_irq = 32'h0000_0204;
`endif

    repeat (2) @(negedge clk);
    chk("rst_fe_valid", {31'd0, fe_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, ic_req_valid}, 32'd0);
    chk("rst_fe_pc", fe_pc, 32'd0);
    chk("rst_fe_isn", fe_isn, 32'd0);
    chk("rst_n_pc", n_pc, 32'd4);
    rst = 1'b1;

    // Sequential fetch, one instruction per three cycles.
    fetch_one(32'h0);
    @(negedge clk); fetch_one(32'h4);
    @(negedge clk); fetch_one(32'h8);

    // Decode stall holds the instruction and suppresses requests.
    stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_fe_valid", {31'd0, fe_valid}, 32'd1);
      chk("stall_fe_pc", fe_pc, 32'h8);
      chk("stall_fe_isn", fe_isn, 32'h8 ^ IsnKey);
      chk("stall_req_valid", {31'd0, ic_req_valid}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clk); fetch_one(32'hC);

    // Jump-register while waiting on a slow response: response squashed.
    rsp_lat = 3;
    @(negedge clk);
    #1 chk("jr_req_addr", ic_req_addr, 32'h10);
    @(negedge clk);
    jr_valid = 1'b1; jr_target = 32'h100; rsp_lat = 1;
    @(negedge clk);
    jr_valid = 1'b0;
    chk("jr_kill_fe_valid0", {31'd0, fe_valid}, 32'd0);
    @(negedge clk);
    chk("jr_kill_fe_valid1", {31'd0, fe_valid}, 32'd0);
    chk("jr_kill_req_valid", {31'd0, ic_req_valid}, 32'd0);
    @(negedge clk); fetch_one(32'h100);

    // All three sources at once in HOLD, with stall asserted.
    irq = 1'b1; jr_valid = 1'b1; jr_target = 32'h200; ji_valid = 1'b1; ji_target = 32'h300;
    stall = 1'b1;
    @(negedge clk);
    irq = 1'b0; jr_valid = 1'b0; ji_valid = 1'b0; stall = 1'b0;
    chk("pri_fe_valid", {31'd0, fe_valid}, 32'd0);
    fetch_one(exp_pri);

    // Interrupt alone.
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    fetch_one(exp_irq);

    // Jump-register beats jump-immediate.
    jr_valid = 1'b1; jr_target = 32'h200; ji_valid = 1'b1; ji_target = 32'h300;
    @(negedge clk);
    jr_valid = 1'b0; ji_valid = 1'b0;
    fetch_one(32'h200);

    // Jump-immediate to the top of the address space, then wrap.
    ji_valid = 1'b1; ji_target = 32'hFFFF_FFFC;
    @(negedge clk);
    ji_valid = 1'b0;
    fetch_one(32'hFFFF_FFFC);
    @(negedge clk); fetch_one(32'h0);

    // Redirect in the same cycle as the response.
    @(negedge clk);
    #1 chk("same_req_addr", ic_req_addr, 32'h4);
    @(negedge clk);
    jr_valid = 1'b1; jr_target = 32'h40;
    @(negedge clk);
    jr_valid = 1'b0;
    chk("same_fe_valid", {31'd0, fe_valid}, 32'd0);
    fetch_one(32'h40);

    // Asynchronous reset while a request is outstanding.
    rsp_lat = 3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_fe_valid", {31'd0, fe_valid}, 32'd0);
    chk("arst_req_valid", {31'd0, ic_req_valid}, 32'd0);
    chk("arst_fe_pc", fe_pc, 32'd0);
    chk("arst_fe_isn", fe_isn, 32'd0);
    @(negedge clk);
    rst = 1'b1; rsp_lat = 1;
    fetch_one(32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
